joypad_poll_sequencer: RTL
==========================

Name: joypad_poll_sequencer

Overview:
- Autonomous joypad poller. On each frame pulse it drives latch/clock on both controller ports, shifts 8 buttons per pad into shadow registers, then serves CPU $4016/$4017 reads from those shadows.
- Decouples CPU read timing from the pad pins.
- Sits between the CPU bus decode and the joypad connector pins; replaces direct pin-driven reads.

Parameters:
- LATCH_CYCLES, 12, clk cycles controller_out_latch is held high per poll (>=1).
- CLK_DIV, 6, clk cycles per controller clock phase (low phase and settle phase each; >=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ph2_falling  in  1  one-clk pulse marking end of CPU bus cycle.
- cpu_addr  in  16  CPU address.
- cpu_rnw  in  1  1=read, 0=write.
- cpu_data_in  in  1  bit0 of CPU write data ($4016 strobe).
- cpu_data_out  out  8  read data, registered.
- poll_req  in  1  one-clk frame pulse (vblank start).
- controller_data1  in  1  pad 1 serial data, active-low.
- controller_data2  in  1  pad 2 serial data, active-low.
- controller_out_latch  out  1  shared pad latch, active-high.
- controller1_out_clk  out  1  pad 1 clock, idle high.
- controller2_out_clk  out  1  pad 2 clock, idle high.
- busy  out  1  high while a poll is in progress.
- buttons1  out  8  pad 1 shadow; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right; 1=pressed.
- buttons2  out  8  pad 2 shadow, same layout.
- buttons_valid  out  1  one-clk pulse when shadows update.

Behaviour:
- Reset: FSM=IDLE; latch=0; both pad clocks=1; busy=0; buttons1/2=0x00; buttons_valid=0; pending=0; cpu_strobe=0; CPU shift regs=0x00; cpu_data_out=0x00. Reset mid-poll aborts immediately; pins return to idle the next cycle; no shadow update.
- All outputs are registered.
- Poll FSM, bit index idx 0..7, phase counter cnt:
  - IDLE: if poll_req or pending: clear pending, latch=1, busy=1, go to LATCH.
  - LATCH: hold LATCH_CYCLES cycles, then latch=0, go to SETTLE.
  - SETTLE: wait CLK_DIV cycles. On the last cycle capture cap1[idx]=~controller_data1 and cap2[idx]=~controller_data2. If idx==7 go to DONE, else drive both clks=0 and go to CLK_LO.
  - CLK_LO: hold clks=0 for CLK_DIV cycles, then clks=1, idx++, go to SETTLE.
  - DONE: buttons1<=cap1, buttons2<=cap2, buttons_valid=1 for one cycle, busy=0, go to IDLE.
- Poll length, from the poll_req accept cycle to the buttons_valid cycle: LATCH_CYCLES + 15*CLK_DIV + 1 clk.
- Exactly 7 clock low pulses per poll; both pad clocks always toggle identically.
- poll_req while busy sets pending (depth 1; further requests are merged). The pending poll starts the cycle after DONE returns to IDLE.
- CPU side:
  - Write strobe: ph2_falling & ~cpu_rnw & addr==$4016 sets cpu_strobe<=cpu_data_in.
  - While cpu_strobe=1, both CPU shift regs continuously reload from buttons1/2.
  - On the write that takes cpu_strobe 1->0, the regs load once more. They hold thereafter.
  - If DONE coincides with a reload, the reload takes the pre-update shadow value.
  - Read $4016 (cpu_rnw & addr match): cpu_data_out<={7'b0, sr1[0]} each clk while selected. $4017 returns sr2[0] the same way. Otherwise cpu_data_out=0x00; it is also cleared on ph2_falling.
  - Shift on read: at ph2_falling of a $4016 read with cpu_strobe=0, sr1<={1'b1, sr1[7:1]}. $4017 does the same with sr2. After 8 reads every further read returns 1.
  - With cpu_strobe=1, reads return current buttons bit0 and do not shift.
- Writes to $4017 are ignored. Polling is never blocked by CPU activity.

Test Plan:
1. Reset; CLK_DIV=4, LATCH_CYCLES=4; pulse poll_req. Check: latch high exactly 4 cycles; 7 clock low pulses of 4 cycles each; buttons_valid at cycle 65 after accept.
2. Pad1 model returns 0xA5 and pad2 0x3C (active-low on pins, LSB first). Require buttons1=0xA5, buttons2=0x3C after valid.
3. After test 2, CPU writes 1 then 0 to $4016, then does 10 reads of $4016. Require bit0 sequence 1,0,1,0,0,1,0,1,1,1. Ten $4017 reads give 0,0,1,1,1,1,0,0,1,1.
4. poll_req pulsed 3 times during a busy poll: exactly one extra poll runs, starting 1 cycle after the first buttons_valid.
5. Assert rst during CLK_LO of bit 3: next cycle clks=1, latch=0, busy=0, buttons unchanged from reset 0x00; a following poll completes normally.
6. Strobe 1->0 write lands on the DONE cycle with old shadow 0x00 and new 0xFF: first $4016 read returns 0; after a new strobe, reads return 1.

Source files
------------

// File: rtl/joypad_poll_sequencer.sv
`timescale 1ns/1ps
// joypad_poll_sequencer
//   Autonomous two-pad joypad poller. A frame pulse (poll_req) starts a poll:
//   the shared latch is raised, then both pad clocks are pulsed low seven
//   times while one button bit per pad is sampled after each settle window.
//   The eight captured bits become the button shadows. CPU reads of
//   $4016/$4017 are then served from CPU-side shift registers loaded from
//   those shadows, so CPU read timing never touches the pad pins.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   ph2_falling           one-clk pulse at the end of a CPU bus cycle
//   cpu_addr/cpu_rnw      CPU address and direction (1 = read)
//   cpu_data_in           bit0 of CPU write data ($4016 strobe)
//   cpu_data_out          registered read data ({7'b0, bit})
//   poll_req              one-clk frame pulse requesting a poll
//   controller_data1/2    pad serial data pins, active-low
//   controller_out_latch  shared pad latch, active-high
//   controller1/2_out_clk pad clocks, idle high
//   busy                  high while a poll is running
//   buttons1/2            button shadows, 1 = pressed
//   buttons_valid         one-clk pulse when the shadows update
module joypad_poll_sequencer #(
    parameter int LATCH_CYCLES = 12,
    parameter int CLK_DIV      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic        cpu_data_in,
    output logic [7:0]  cpu_data_out,
    input  logic        poll_req,
    input  logic        controller_data1,
    input  logic        controller_data2,
    output logic        controller_out_latch,
    output logic        controller1_out_clk,
    output logic        controller2_out_clk,
    output logic        busy,
    output logic [7:0]  buttons1,
    output logic [7:0]  buttons2,
    output logic        buttons_valid
);

    localparam int CNT_MAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [15:0]   ADDR_JOY1  = 16'h4016;
    localparam logic [15:0]   ADDR_JOY2  = 16'h4017;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETTLE,
        S_CLK_LO,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            latch_q, latch_d;
    logic            pclk_q, pclk_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            pending_q, pending_d;
    logic [7:0]      cap1_q, cap1_d, cap2_q, cap2_d;
    logic [7:0]      btn1_q, btn1_d, btn2_q, btn2_d;
    logic            strobe_q, strobe_d;
    logic [7:0]      sr1_q, sr1_d, sr2_q, sr2_d;
    logic [7:0]      dout_q, dout_d;

    logic            sel1, sel2, wr_strobe;
    logic            rd1_bit, rd2_bit;

    // Poll sequencer: next state and pin drive
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        latch_d   = latch_q;
        pclk_d    = pclk_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        pending_d = pending_q;
        cap1_d    = cap1_q;
        cap2_d    = cap2_q;
        btn1_d    = btn1_q;
        btn2_d    = btn2_q;

        // Any request outside IDLE is remembered once; extra ones merge.
        if (state_q != S_IDLE && poll_req) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (poll_req || pending_q) begin
                    pending_d = 1'b0;
                    latch_d   = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    idx_d     = 3'd0;
                    state_d   = S_LATCH;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    latch_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == DIV_LAST) begin
                    cap1_d[idx_q] = ~controller_data1;
                    cap2_d[idx_q] = ~controller_data2;
                    cnt_d         = '0;
                    if (idx_q == 3'd7) begin
                        // Shadows and valid register together so the
                        // valid cycle already shows the new buttons.
                        btn1_d  = cap1_d;
                        btn2_d  = cap2_d;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        pclk_d  = 1'b0;
                        state_d = S_CLK_LO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CLK_LO: begin
                if (cnt_q == DIV_LAST) begin
                    pclk_d  = 1'b1;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // CPU side: strobe, shift registers and read data
    always_comb begin
        sel1      = cpu_rnw && (cpu_addr == ADDR_JOY1);
        sel2      = cpu_rnw && (cpu_addr == ADDR_JOY2);
        wr_strobe = ph2_falling && !cpu_rnw && (cpu_addr == ADDR_JOY1);

        strobe_d = wr_strobe ? cpu_data_in : strobe_q;

        // Reload uses the registered shadows, so a reload coinciding with a
        // shadow update takes the old value. The 1->0 write cycle still
        // sees strobe_q=1 and therefore performs the final load.
        sr1_d = sr1_q;
        sr2_d = sr2_q;
        if (strobe_q) begin
            sr1_d = btn1_q;
            sr2_d = btn2_q;
        end else begin
            if (ph2_falling && sel1) sr1_d = {1'b1, sr1_q[7:1]};
            if (ph2_falling && sel2) sr2_d = {1'b1, sr2_q[7:1]};
        end

        rd1_bit = strobe_q ? btn1_q[0] : sr1_q[0];
        rd2_bit = strobe_q ? btn2_q[0] : sr2_q[0];

        dout_d = 8'h00;
        if (!ph2_falling) begin
            if (sel1)      dout_d = {7'b0, rd1_bit};
            else if (sel2) dout_d = {7'b0, rd2_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            latch_q   <= 1'b0;
            pclk_q    <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            btn1_q    <= 8'h00;
            btn2_q    <= 8'h00;
            strobe_q  <= 1'b0;
            sr1_q     <= 8'h00;
            sr2_q     <= 8'h00;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            latch_q   <= latch_d;
            pclk_q    <= pclk_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            btn1_q    <= btn1_d;
            btn2_q    <= btn2_d;
            strobe_q  <= strobe_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            dout_q    <= dout_d;
        end
    end

    // Capture bits are fully rewritten every poll before use.
    always_ff @(posedge clk) begin
        cap1_q <= cap1_d;
        cap2_q <= cap2_d;
    end

    assign cpu_data_out         = dout_q;
    assign controller_out_latch = latch_q;
    assign controller1_out_clk  = pclk_q;
    assign controller2_out_clk  = pclk_q;
    assign busy                 = busy_q;
    assign buttons1             = btn1_q;
    assign buttons2             = btn2_q;
    assign buttons_valid        = valid_q;

endmodule
